arb_requestor_agent: RTL and testbench



---
 rtl/arb_requestor_agent_if.sv | 36 +++
 rtl/arb_requestor_agent.sv | 156 +++++++++++++++
 tb/tb_arb_requestor_agent.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_requestor_agent_if.sv
// ---------------------------------------------------------------------------
// arb_requestor_agent_if
// Bundles the producer-side packet handshake, the arbiter req/grant pair and
// the issued-packet bus of one requestor agent.
//   slave  : seen by the agent (takes packets and grant, drives req/out/count)
//   master : seen by the producer/arbiter side
// ---------------------------------------------------------------------------
interface arb_requestor_agent_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int TIME_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_prior;
  logic              req;
  logic              grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_prior;
  logic [TIME_W-1:0] out_time;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_data, in_prior, grant,
    output in_ready, req, out_valid, out_data, out_prior, out_time, count
  );

  modport master (
    output in_valid, in_data, in_prior, grant,
    input  in_ready, req, out_valid, out_data, out_prior, out_time, count
  );
endinterface

// File: rtl/arb_requestor_agent.sv
// ---------------------------------------------------------------------------
// arb_requestor_agent
// Requestor-side endpoint of the weighted FCFS round-robin arbiter. Queues
// prioritised packets with a push timestamp, requests the bus while packets
// are pending, drains only while granted, and yields after MAX_BURST pops.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : arb_requestor_agent_if.slave
//            in_valid/in_ready/in_data/in_prior : packet push handshake
//            req/grant                          : arbiter request/grant bit
//            out_valid/out_data/out_prior/out_time : issued packet
//            count                              : FIFO occupancy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing requested; waits for a queued packet
// REQ      | req high, waiting for grant to take the first pop
// XFER     | req high, popping one packet per granted cycle
// BACKOFF  | req low for one cycle after losing grant or hitting burst
// ---------------------------------------------------------------------------
module arb_requestor_agent #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 8,
  parameter int TIME_W    = 32,
  parameter int MAX_BURST = 8
) (
  input logic                clk,
  input logic                reset,
  arb_requestor_agent_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int ENTRY_W = DATA_W + 3 + TIME_W;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_BACKOFF} state_t;

  state_t             r_state, w_state_nxt;
  logic [BURST_W-1:0] r_burst_cnt, w_burst_nxt, w_burst_inc;
  logic [TIME_W-1:0]  r_timer;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [2:0]         r_out_prior;
  logic [TIME_W-1:0]  r_out_time;

  logic               w_in_ready, w_push, w_pop, w_req, w_last_pop;
  logic [2:0]         w_prior_norm;
  logic [ENTRY_W-1:0] w_head;

  // No bypass: a full FIFO refuses a push even when a pop happens that edge.
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_req       = (r_state == ST_REQ) || (r_state == ST_XFER);
  assign w_pop       = w_req && bus.grant && (r_count != '0) &&
                       (r_burst_cnt < BURST_W'(MAX_BURST));
  assign w_last_pop  = w_pop && (r_count == CNT_W'(1)) && !w_push;
  assign w_burst_inc = r_burst_cnt + BURST_W'(1);
  assign w_head      = r_mem[r_rd_ptr];

  // Anything that is not a clean one-hot priority is treated as LO.
  always_comb begin
    w_prior_norm = 3'b001;
    case (bus.in_prior)
      3'b001, 3'b010, 3'b100: w_prior_norm = bus.in_prior;
      default:                w_prior_norm = 3'b001;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (w_pop) begin
          if (MAX_BURST == 1) begin
            w_state_nxt = ST_BACKOFF;
          end else begin
            w_state_nxt = ST_XFER;
            w_burst_nxt = BURST_W'(1);
          end
        end
      end
      ST_XFER: begin
        if (!bus.grant) begin
          w_state_nxt = (r_count != '0) ? ST_BACKOFF : ST_IDLE;
        end else if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pop && (w_burst_inc == BURST_W'(MAX_BURST))) begin
          w_state_nxt = ST_BACKOFF;
        end else if (w_pop) begin
          w_burst_nxt = w_burst_inc;
        end else begin
          // Granted but unable to pop: give the bus back.
          w_state_nxt = (r_count != '0) ? ST_BACKOFF : ST_IDLE;
        end
      end
      ST_BACKOFF: begin
        w_state_nxt = (r_count != '0) ? ST_REQ : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_timer     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_prior <= '0;
      r_out_time  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_timer     <= r_timer + TIME_W'(1);
      r_out_valid <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_out_data  <= w_head[ENTRY_W-1 -: DATA_W];
        r_out_prior <= w_head[TIME_W +: 3];
        r_out_time  <= w_head[TIME_W-1:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= {bus.in_data, w_prior_norm, r_timer};
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.req       = w_req;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_prior = r_out_prior;
  assign bus.out_time  = r_out_time;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_arb_requestor_agent.sv
module tb_arb_requestor_agent;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  arb_requestor_agent_if #(.DEPTH(4), .DATA_W(8), .TIME_W(32)) bus_a ();
  arb_requestor_agent_if #(.DEPTH(4), .DATA_W(8), .TIME_W(32)) bus_b ();

  arb_requestor_agent #(.DEPTH(4), .DATA_W(8), .TIME_W(32), .MAX_BURST(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  arb_requestor_agent #(.DEPTH(4), .DATA_W(8), .TIME_W(32), .MAX_BURST(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d, input logic [2:0] p);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_prior = p;
  endtask

  task automatic do_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_prior = '0; bus_a.grant = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_prior = '0; bus_b.grant = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_val("rst_count", bus_a.count, 0);
    check_val("rst_req", bus_a.req, 0);
    check_val("rst_ovalid", bus_a.out_valid, 0);
    check_val("rst_in_ready", bus_a.in_ready, 1);
    check_val("rst_odata", bus_a.out_data, 0);
    check_val("rst_otime", bus_a.out_time, 0);

    // Test 1: three pushes, grant held, in-order drain
    bus_a.grant = 1'b1;
    push_a(8'h11, 3'b001); tick();
    push_a(8'h22, 3'b010); tick();
    check_val("t1_req_up", bus_a.req, 1);
    push_a(8'h33, 3'b100); tick();
    check_val("t1_ov0", bus_a.out_valid, 1);
    check_val("t1_d0", bus_a.out_data, 8'h11);
    check_val("t1_p0", bus_a.out_prior, 3'b001);
    check_val("t1_t0", bus_a.out_time, 0);
    bus_a.in_valid = 1'b0; tick();
    check_val("t1_ov1", bus_a.out_valid, 1);
    check_val("t1_d1", bus_a.out_data, 8'h22);
    check_val("t1_t1", bus_a.out_time, 1);
    tick();
    check_val("t1_ov2", bus_a.out_valid, 1);
    check_val("t1_d2", bus_a.out_data, 8'h33);
    check_val("t1_p2", bus_a.out_prior, 3'b100);
    check_val("t1_t2", bus_a.out_time, 2);
    check_val("t1_req_low", bus_a.req, 0);
    check_val("t1_count", bus_a.count, 0);
    tick();
    check_val("t1_ov_end", bus_a.out_valid, 0);
    check_val("t1_hold", bus_a.out_data, 8'h33);

    // Test 2: fill to DEPTH, overflow refused, no bypass on pop cycle
    do_reset();
    push_a(8'hA0, 3'b001); tick();
    push_a(8'hA1, 3'b001); tick();
    push_a(8'hA2, 3'b001); tick();
    push_a(8'hA3, 3'b001); tick();
    check_val("t2_full_cnt", bus_a.count, 4);
    check_val("t2_not_ready", bus_a.in_ready, 0);
    push_a(8'hA4, 3'b001); tick();
    check_val("t2_5th_drop", bus_a.count, 4);
    bus_a.grant = 1'b1;
    push_a(8'hB5, 3'b010); tick();
    check_val("t2_pop_ov", bus_a.out_valid, 1);
    check_val("t2_pop_d", bus_a.out_data, 8'hA0);
    check_val("t2_nobypass", bus_a.count, 3);
    bus_a.grant = 1'b0; tick();
    check_val("t2_push_next", bus_a.count, 4);
    check_val("t2_backoff_req", bus_a.req, 0);
    bus_a.in_valid = 1'b0; bus_a.grant = 1'b1; tick();
    check_val("t2_rereq", bus_a.req, 1);
    check_val("t2_no_pop_bo", bus_a.out_valid, 0);
    tick(); check_val("t2_d1", bus_a.out_data, 8'hA1);
    tick(); check_val("t2_d2", bus_a.out_data, 8'hA2);
    tick(); check_val("t2_d3", bus_a.out_data, 8'hA3);
    tick();
    check_val("t2_d4", bus_a.out_data, 8'hB5);
    check_val("t2_p4", bus_a.out_prior, 3'b010);
    check_val("t2_empty", bus_a.count, 0);
    check_val("t2_idle", bus_a.req, 0);

    // Test 3: MAX_BURST=2 instance yields after two pops
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_data = 8'hE0 + 8'(i); bus_b.in_prior = 3'b001;
      tick();
    end
    bus_b.in_valid = 1'b0; bus_b.grant = 1'b1;
    tick();
    check_val("t3_d0", bus_b.out_data, 8'hE0);
    check_val("t3_req0", bus_b.req, 1);
    tick();
    check_val("t3_d1", bus_b.out_data, 8'hE1);
    check_val("t3_yield", bus_b.req, 0);
    check_val("t3_cnt", bus_b.count, 2);
    tick();
    check_val("t3_rereq", bus_b.req, 1);
    check_val("t3_gap", bus_b.out_valid, 0);
    tick();
    check_val("t3_d2", bus_b.out_data, 8'hE2);
    tick();
    check_val("t3_d3", bus_b.out_data, 8'hE3);
    check_val("t3_idle", bus_b.req, 0);
    check_val("t3_empty", bus_b.count, 0);

    // Test 4: grant drops after first pop
    do_reset();
    push_a(8'h41, 3'b001); tick();
    push_a(8'h42, 3'b010); tick();
    push_a(8'h43, 3'b100); tick();
    bus_a.in_valid = 1'b0; bus_a.grant = 1'b1; tick();
    check_val("t4_d0", bus_a.out_data, 8'h41);
    bus_a.grant = 1'b0; tick();
    check_val("t4_bo_req", bus_a.req, 0);
    check_val("t4_bo_ov", bus_a.out_valid, 0);
    tick();
    check_val("t4_rereq", bus_a.req, 1);
    bus_a.grant = 1'b1; tick();
    check_val("t4_d1", bus_a.out_data, 8'h42);
    tick();
    check_val("t4_d2", bus_a.out_data, 8'h43);
    check_val("t4_p2", bus_a.out_prior, 3'b100);
    check_val("t4_idle", bus_a.req, 0);

    // Test 5: timestamps and non-one-hot priority
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    push_a(8'h55, 3'b010); tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    push_a(8'h99, 3'b011); tick();
    bus_a.in_valid = 1'b0; bus_a.grant = 1'b1; tick();
    check_val("t5_d0", bus_a.out_data, 8'h55);
    check_val("t5_t0", bus_a.out_time, 5);
    check_val("t5_p0", bus_a.out_prior, 3'b010);
    tick();
    check_val("t5_d1", bus_a.out_data, 8'h99);
    check_val("t5_t1", bus_a.out_time, 9);
    check_val("t5_p1_lo", bus_a.out_prior, 3'b001);

    // Test 6: reset in XFER with 3 queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_a(8'hC0 + 8'(i), 3'b001); tick();
    end
    bus_a.in_valid = 1'b0; bus_a.grant = 1'b1; tick();
    check_val("t6_pre_d", bus_a.out_data, 8'hC0);
    check_val("t6_pre_cnt", bus_a.count, 3);
    reset = 1'b1; tick();
    check_val("t6_cnt", bus_a.count, 0);
    check_val("t6_req", bus_a.req, 0);
    check_val("t6_ov", bus_a.out_valid, 0);
    check_val("t6_in_ready", bus_a.in_ready, 1);
    reset = 1'b0;
    push_a(8'hD7, 3'b100); tick();
    check_val("t6_no_pop0", bus_a.out_valid, 0);
    check_val("t6_cnt1", bus_a.count, 1);
    bus_a.in_valid = 1'b0; tick();
    check_val("t6_no_pop1", bus_a.out_valid, 0);
    tick();
    check_val("t6_new_ov", bus_a.out_valid, 1);
    check_val("t6_new_d", bus_a.out_data, 8'hD7);
    check_val("t6_timer0", bus_a.out_time, 0);
    check_val("t6_end_cnt", bus_a.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
